// File: rtl/timebase_pkg.sv
// Shared constants and helpers for the timebase prescaler chain.
package timebase_pkg;

    localparam int DIV_INIT_DEFAULT = 100;

    // Width of the stage-select field; a single stage still needs one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/timebase_chain_tick_prescaler.sv
// One divider stage: programmable divisor, terminal compare and registered tick.
module tick_prescaler #(
    parameter int               CNT_W    = 7,
    parameter logic [CNT_W-1:0] DIV_INIT = 7'd100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_data,
    input  logic             strobe,
    output logic             tick,
    output logic             hit,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] term;

    // A zero divisor behaves as one: every strobe is terminal.
    always_comb begin
        term = '0;
        if (div != '0) term = div - CNT_W'(1);
    end

    // hit is the tick about to be registered; the chain uses it for the one-shot flag.
    assign hit = strobe && !clr && !load && (cnt == term);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
            div  <= DIV_INIT;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (load) begin
            div  <= load_data;
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= hit;
            if (strobe) begin
                if (cnt == term) cnt <= '0;
                else             cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/timebase_chain.sv
// Cascade of tick prescalers deriving slower timebase strobes from one tick input.
module timebase_chain
    import timebase_pkg::*;
#(
    parameter int  NUM_STAGES = 3,
    parameter int  CNT_W      = 7,
    parameter int  DIV_INIT   = DIV_INIT_DEFAULT,
    localparam int SEL_W      = sel_width(NUM_STAGES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick_in,
    input  logic                        en,
    input  logic                        clr,
    input  logic                        oneshot,
    input  logic                        div_wr,
    input  logic [SEL_W-1:0]            div_sel,
    input  logic [CNT_W-1:0]            div_data,
    output logic [NUM_STAGES-1:0]       tick_out,
    output logic [NUM_STAGES*CNT_W-1:0] cnt,
    output logic                        done
);

    logic [NUM_STAGES-1:0] strobe;
    logic [NUM_STAGES-1:0] load;
    logic [NUM_STAGES-1:0] hit;

    // Once a one-shot run completes, only stage 0 is starved; later stages drain.
    assign strobe[0] = tick_in && en && !done;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        if (k > 0) begin : g_link
            assign strobe[k] = tick_out[k-1];
        end

        assign load[k] = div_wr && (div_sel == SEL_W'(k));

        tick_prescaler #(
            .CNT_W    (CNT_W),
            .DIV_INIT (CNT_W'(DIV_INIT))
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr),
            .load      (load[k]),
            .load_data (div_data),
            .strobe    (strobe[k]),
            .tick      (tick_out[k]),
            .hit       (hit[k]),
            .cnt       (cnt[k*CNT_W +: CNT_W])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done <= 1'b0;
        end else if (clr) begin
            done <= 1'b0;
        end else if (oneshot && hit[NUM_STAGES-1]) begin
            done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_timebase_chain.sv
// Directed self-checking bench for timebase_chain with default parameters.
module tb_timebase_chain;

    localparam int NS    = 3;
    localparam int CW    = 7;
    localparam int SEL_W = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              tick_in = 1'b0;
    logic              en = 1'b0;
    logic              clr = 1'b0;
    logic              oneshot = 1'b0;
    logic              div_wr = 1'b0;
    logic [SEL_W-1:0]  div_sel = '0;
    logic [CW-1:0]     div_data = '0;
    logic [NS-1:0]     tick_out;
    logic [NS*CW-1:0]  cnt;
    logic              done;

    logic [CW-1:0] cnt0, cnt1, cnt2;
    assign cnt0 = cnt[0*CW +: CW];
    assign cnt1 = cnt[1*CW +: CW];
    assign cnt2 = cnt[2*CW +: CW];

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    timebase_chain #(.NUM_STAGES(NS), .CNT_W(CW), .DIV_INIT(100)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_in  (tick_in),
        .en       (en),
        .clr      (clr),
        .oneshot  (oneshot),
        .div_wr   (div_wr),
        .div_sel  (div_sel),
        .div_data (div_data),
        .tick_out (tick_out),
        .cnt      (cnt),
        .done     (done)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0; tick_in = 1'b0; en = 1'b1; clr = 1'b0;
        oneshot = 1'b0; div_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // drivers
    task automatic write_div(input int sel, input int data);
        tick_in  = 1'b0;
        div_sel  = SEL_W'(sel);
        div_data = CW'(data);
        div_wr   = 1'b1;
        step();
        div_wr   = 1'b0;
    endtask

    task automatic do_clr();
        tick_in = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got %0h expected 0", cnt); end
        n_checks++;
        if (tick_out !== '0) begin n_fail++; $display("FAIL reset_tick got %0b expected 0", tick_out); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b expected 0", done); end
    endtask

    task automatic test_default_div();
        int p0, p12, at;
        p0 = 0; p12 = 0; at = -1;
        en = 1'b1; tick_in = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (tick_out[0]) begin p0++; at = i; end
            if (tick_out[2:1] != 2'b00) p12++;
        end
        tick_in = 1'b0;
        step();
        if (tick_out[0]) p0++;
        if (tick_out[2:1] != 2'b00) p12++;
        n_checks++;
        if (p0 !== 1) begin n_fail++; $display("FAIL def_pulses got %0d expected 1", p0); end
        n_checks++;
        if (at !== 100) begin n_fail++; $display("FAIL def_pulse_at got %0d expected 100", at); end
        n_checks++;
        if (cnt0 !== 7'd0) begin n_fail++; $display("FAIL def_cnt0 got %0d expected 0", cnt0); end
        n_checks++;
        if (p12 !== 0) begin n_fail++; $display("FAIL def_upper got %0d expected 0", p12); end
    endtask

    task automatic test_cascade();
        int p0, p1, p2, at2;
        logic [31:0] exp_v;
        p0 = 0; p1 = 0; p2 = 0; at2 = -1;
        write_div(0, 10); write_div(1, 10); write_div(2, 10);
        exp_q.push_back(100); exp_q.push_back(10); exp_q.push_back(1);
        for (int i = 1; i <= 1004; i++) begin
            tick_in = (i <= 1000);
            step();
            if (tick_out[0]) p0++;
            if (tick_out[1]) p1++;
            if (tick_out[2]) begin p2++; at2 = i; end
        end
        tick_in = 1'b0;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (p0 !== exp_v) begin n_fail++; $display("FAIL casc_p0 got %0d expected %0d", p0, exp_v); end
        exp_v = exp_q.pop_front();
        n_checks++;
        if (p1 !== exp_v) begin n_fail++; $display("FAIL casc_p1 got %0d expected %0d", p1, exp_v); end
        exp_v = exp_q.pop_front();
        n_checks++;
        if (p2 !== exp_v) begin n_fail++; $display("FAIL casc_p2 got %0d expected %0d", p2, exp_v); end
        n_checks++;
        if (at2 !== 1002) begin n_fail++; $display("FAIL casc_lat got %0d expected 1002", at2); end
        n_checks++;
        if (cnt !== '0) begin n_fail++; $display("FAIL casc_cnt got %0h expected 0", cnt); end
    endtask

    task automatic test_div_zero_one();
        logic [11:0] pat;
        pat = 12'b1011_0011_1010;
        for (int d = 0; d <= 1; d++) begin
            write_div(0, d);
            for (int i = 0; i < 12; i++) begin
                tick_in = pat[i];
                step();
                n_checks++;
                if (tick_out[0] !== pat[i]) begin
                    n_fail++;
                    $display("FAIL div%0d_mirror[%0d] got %0b expected %0b", d, i, tick_out[0], pat[i]);
                end
            end
            tick_in = 1'b0;
            n_checks++;
            if (cnt0 !== 7'd0) begin n_fail++; $display("FAIL div%0d_cnt0 got %0d expected 0", d, cnt0); end
        end
    endtask

    task automatic test_oneshot();
        int at2, atd, extra, nz;
        at2 = -1; atd = -1; extra = 0; nz = 0;
        oneshot = 1'b1;
        write_div(0, 2); write_div(1, 2); write_div(2, 2);
        for (int i = 1; i <= 12; i++) begin
            tick_in = (i <= 8);
            step();
            if (tick_out[2] && at2 < 0) at2 = i;
            if (done && atd < 0) atd = i;
        end
        tick_in = 1'b0;
        n_checks++;
        if (at2 !== 10) begin n_fail++; $display("FAIL os_tick2_at got %0d expected 10", at2); end
        n_checks++;
        if (atd !== 10) begin n_fail++; $display("FAIL os_done_at got %0d expected 10", atd); end
        oneshot = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick_in = 1'b1;
            step();
            if (tick_out != '0) extra++;
            if (cnt != '0) nz++;
        end
        tick_in = 1'b0;
        n_checks++;
        if (extra !== 0) begin n_fail++; $display("FAIL os_blocked_ticks got %0d expected 0", extra); end
        n_checks++;
        if (nz !== 0) begin n_fail++; $display("FAIL os_blocked_cnt got %0d expected 0", nz); end
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL os_sticky got %0b expected 1", done); end
        do_clr();
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL os_clr_done got %0b expected 0", done); end
        tick_in = 1'b1;
        step();
        n_checks++;
        if (cnt0 !== 7'd1) begin n_fail++; $display("FAIL os_resume_cnt got %0d expected 1", cnt0); end
        step();
        tick_in = 1'b0;
        n_checks++;
        if (tick_out[0] !== 1'b1) begin n_fail++; $display("FAIL os_resume_tick got %0b expected 1", tick_out[0]); end
    endtask

    task automatic test_async_reset();
        int p0, at;
        p0 = 0; at = -1;
        apply_reset();
        tick_in = 1'b1;
        repeat (57) step();
        tick_in = 1'b0;
        n_checks++;
        if (cnt0 !== 7'd57) begin n_fail++; $display("FAIL ar_pre_cnt got %0d expected 57", cnt0); end
        #3 rst = 1'b0;
        #1;
        n_checks++;
        if (cnt !== '0) begin n_fail++; $display("FAIL ar_cnt got %0h expected 0", cnt); end
        n_checks++;
        if (tick_out !== '0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_out got tick=%0b done=%0b expected 0 0", tick_out, done);
        end
        #1 rst = 1'b1;
        tick_in = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (tick_out[0]) begin p0++; at = i; end
        end
        tick_in = 1'b0;
        n_checks++;
        if (p0 !== 1 || at !== 100) begin
            n_fail++;
            $display("FAIL ar_div got pulses=%0d at=%0d expected 1 at 100", p0, at);
        end
    endtask

    task automatic test_load_vs_strobe();
        int p0, at;
        p0 = 0; at = -1;
        write_div(0, 10);
        tick_in = 1'b1;
        repeat (9) step();
        n_checks++;
        if (cnt0 !== 7'd9) begin n_fail++; $display("FAIL ld_pre_cnt got %0d expected 9", cnt0); end
        div_sel = 2'd0; div_data = 7'd4; div_wr = 1'b1;
        step();
        div_wr = 1'b0;
        n_checks++;
        if (tick_out[0] !== 1'b0 || cnt0 !== 7'd0) begin
            n_fail++;
            $display("FAIL ld_drop got tick=%0b cnt0=%0d expected 0 0", tick_out[0], cnt0);
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            if (tick_out[0]) begin p0++; at = i; end
        end
        tick_in = 1'b0;
        n_checks++;
        if (p0 !== 1 || at !== 4) begin
            n_fail++;
            $display("FAIL ld_newdiv got pulses=%0d at=%0d expected 1 at 4", p0, at);
        end
    endtask

    task automatic test_sel_range_and_en();
        int p0;
        p0 = 0;
        tick_in = 1'b1;
        repeat (2) step();
        write_div(3, 1);
        n_checks++;
        if (cnt0 !== 7'd2) begin n_fail++; $display("FAIL sel_oob_cnt got %0d expected 2", cnt0); end
        en = 1'b0; tick_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (tick_out[0]) p0++;
        end
        n_checks++;
        if (cnt0 !== 7'd2 || p0 !== 0) begin
            n_fail++;
            $display("FAIL en_gate got cnt0=%0d pulses=%0d expected 2 0", cnt0, p0);
        end
        en = 1'b1;
        step();
        n_checks++;
        if (tick_out[0] !== 1'b0) begin n_fail++; $display("FAIL en_resume1 got %0b expected 0", tick_out[0]); end
        step();
        tick_in = 1'b0;
        n_checks++;
        if (tick_out[0] !== 1'b1) begin n_fail++; $display("FAIL en_resume2 got %0b expected 1", tick_out[0]); end
    endtask

    initial begin
        test_reset();
        test_default_div();
        test_cascade();
        test_div_zero_one();
        test_oneshot();
        test_async_reset();
        test_load_vs_strobe();
        test_sel_range_and_en();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
